// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one full-subtractor cell plus borrow FF
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] sa, sb, res, res_n;
    logic [CW-1:0] cnt;
    logic bor, d, bor_n;
    always_comb begin
        d = sa[0] ^ sb[0] ^ bor;
        bor_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor);
        res_n = {d, res[WIDTH-1:1]};
    end
    // diff/borrow_out load only on entry to DONE, so partial results never show
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            borrow_out <= 1'b0;
            sa <= '0;
            sb <= '0;
            res <= '0;
            bor <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa <= a;
                    sb <= b;
                    bor <= 1'b0;
                    cnt <= '0;
                    busy <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    res <= res_n;
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    bor <= bor_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        done <= 1'b1;
                        diff <= res_n;
                        borrow_out <= bor_n;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random and directed checks of 4- and 8-bit serial subtractors
module tb_serial_subtractor;
    logic clk = 0, rst = 1;
    logic s4 = 0, s8 = 0;
    logic [3:0] a4 = 0, b4 = 0, diff4;
    logic [7:0] a8 = 0, b8 = 0, diff8;
    logic busy4, done4, bo4, busy8, done8, bo8;
    logic [4:0] last4 = 0;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4));
    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));

    task automatic op4(input logic [3:0] av, bv);
        logic [4:0] exp;
        int lat, bc;
        exp = {1'b0, av} - {1'b0, bv};
        @(negedge clk);
        a4 = av; b4 = bv; s4 = 1;
        @(posedge clk); #1;
        s4 = 0;
        lat = 0;
        bc = busy4;
        while (!done4 && lat < 20) begin
            total++;
            if ({bo4, diff4} !== last4) $display("FAIL hold4 %h-%h got %h want %h", av, bv, {bo4, diff4}, last4);
            else passed++;
            @(posedge clk); #1;
            lat++;
            bc += busy4;
        end
        total++;
        if (lat !== 4) $display("FAIL latency4 %h-%h got %0d want 4", av, bv, lat); else passed++;
        total++;
        if ({bo4, diff4} !== exp) $display("FAIL result4 %h-%h got %h want %h", av, bv, {bo4, diff4}, exp); else passed++;
        @(posedge clk); #1;
        total++;
        if (done4 !== 0 || busy4 !== 0) $display("FAIL idle4 %h-%h got done=%b busy=%b want 0 0", av, bv, done4, busy4); else passed++;
        total++;
        if (bc !== 5) $display("FAIL busylen4 %h-%h got %0d want 5", av, bv, bc); else passed++;
        last4 = exp;
    endtask

    task automatic op8(input logic [7:0] av, bv);
        logic [8:0] exp;
        int lat;
        exp = {1'b0, av} - {1'b0, bv};
        @(negedge clk);
        a8 = av; b8 = bv; s8 = 1;
        @(posedge clk); #1;
        s8 = 0;
        lat = 0;
        while (!done8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== 8 || {bo8, diff8} !== exp)
            $display("FAIL op8 %h-%h got lat=%0d res=%h want lat=8 res=%h", av, bv, lat, {bo8, diff8}, exp);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        total++;
        if ({busy4, done4, bo4, diff4, busy8, done8, bo8, diff8} !== '0)
            $display("FAIL reset got busy4=%b done4=%b diff4=%h busy8=%b diff8=%h want zeros", busy4, done4, diff4, busy8, diff8);
        else passed++;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_basic;
        op4(4'd9, 4'd5);
        op4(4'd5, 4'd9);
        for (int i = 0; i < 20; i++) op4(4'($urandom), 4'($urandom));
    endtask

    task automatic test_back_to_back;
        op4(4'd0, 4'd0);
        op4(4'd15, 4'd15);
        op4(4'd0, 4'd1);
    endtask

    task automatic test_ignore_start;
        int n;
        @(negedge clk);
        a4 = 9; b4 = 5; s4 = 1;
        @(negedge clk);
        s4 = 0;
        @(negedge clk);
        a4 = 1; b4 = 0; s4 = 1;
        @(negedge clk);
        s4 = 0;
        n = 0;
        while (!done4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if ({bo4, diff4} !== 5'h04) $display("FAIL ignore got %h want 04", {bo4, diff4}); else passed++;
        @(posedge clk); #1;
        last4 = 5'h04;
    endtask

    task automatic test_held_start;
        int t[$];
        int n;
        @(negedge clk);
        a4 = 3; b4 = 1; s4 = 1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done4) begin
                t.push_back(c);
                total++;
                if ({bo4, diff4} !== 5'h02) $display("FAIL held_res got %h want 02", {bo4, diff4}); else passed++;
            end
        end
        s4 = 0;
        total++;
        if (t.size() < 3) $display("FAIL held_count got %0d want >=3", t.size());
        else if (t[1] - t[0] !== 6 || t[2] - t[1] !== 6)
            $display("FAIL held_period got %0d,%0d want 6,6", t[1] - t[0], t[2] - t[1]);
        else passed++;
        n = 0;
        while (busy4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        last4 = 5'h02;
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        a4 = 5; b4 = 9; s4 = 1;
        @(negedge clk);
        s4 = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1;
        #1;
        total++;
        if (busy4 !== 0 || done4 !== 0 || {bo4, diff4} !== 5'h00)
            $display("FAIL rstmid got busy=%b done=%b res=%h want 0 0 00", busy4, done4, {bo4, diff4});
        else passed++;
        @(negedge clk);
        rst = 0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            seen += done4;
        end
        total++;
        if (seen !== 0) $display("FAIL rstmid_done got %0d pulses want 0", seen); else passed++;
        last4 = 0;
        op4(4'd9, 4'd5);
    endtask

    task automatic test_width8;
        op8(8'd0, 8'd0);
        op8(8'd255, 8'd255);
        op8(8'd0, 8'd255);
        op8(8'd255, 8'd0);
        op8(8'd128, 8'd1);
        for (int i = 0; i < 400; i++) op8(8'($urandom), 8'($urandom));
    endtask

    initial begin
        #12;
        test_reset;
        test_basic;
        test_back_to_back;
        test_ignore_start;
        test_held_start;
        test_reset_mid;
        test_width8;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
